alu_op_dispatcher: RTL and testbench
====================================

# alu_op_dispatcher

Front-end sequencer for the 8-bit ALU: accepts one operation request (opcode plus two operands) over a valid/ready handshake and drives the shared opcode select and operand bus. For MULTI and DIV it runs the start/done handshake with the multi-cycle multiplier and divider. It captures the selected result from the ALU result multiplexer and returns it over a valid/ready response channel with an error flag. It is the issuing end of the result-select path: it produces the 3-bit select that the result multiplexer consumes.

## Interface
- `WIDTH`, 8 — operand and result width.
- `TIMEOUT`, 32 — maximum cycles spent in WAIT before the operation aborts with an error; must be ≥ 2.
- `clk` in 1 — single clock; all state updates on the rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `req_valid` in 1 — request present.
- `req_ready` out 1 — block can accept a request.
- `req_op` in 3 — opcode: NOT=000, AND=001, OR=010, XOR=011, ADD=100, SUB=101, MULTI=110, DIV=111.
- `req_a`, `req_b` in WIDTH — operands.
- `op_sel` out 3 — registered opcode to the result multiplexer select.
- `opnd_a`, `opnd_b` out WIDTH — registered operands to all functional units.
- `mul_start`, `div_start` out 1 — one-cycle start pulses.
- `mul_done`, `div_done` in 1 — unit completion; sampled only in WAIT.
- `alu_res` in WIDTH — result multiplexer output.
- `rsp_valid` out 1 — response present.
- `rsp_ready` in 1 — consumer accepts the response.
- `rsp_data` out WIDTH — captured result.
- `rsp_op` out 3 — opcode of this response.
- `rsp_err` out 1 — divide-by-zero or timeout.

## Operation
- States: IDLE, EXEC, WAIT, RESP. There is one operation in flight at a time.
- IDLE: `req_ready`=1. When `req_valid`=1, load `op_sel`←`req_op`, `opnd_a`←`req_a`, `opnd_b`←`req_b`, then go to EXEC.
- EXEC, lasts exactly one cycle:
  - Opcodes 000–101: capture `alu_res` into `rsp_data`, set `rsp_err`=0, go to RESP.
  - MULTI: `mul_start`=1 this cycle, clear the wait counter, go to WAIT.
  - DIV with `opnd_b`≠0: `div_start`=1 this cycle, clear the wait counter, go to WAIT.
  - DIV with `opnd_b`=0: no start pulse; `rsp_data`=all ones, `rsp_err`=1, go to RESP.
- WAIT: the counter increments every cycle.
  - If the matching done input (`mul_done` for MULTI, `div_done` for DIV) is 1: capture `alu_res`, set `rsp_err`=0, go to RESP.
  - Otherwise, when the counter reaches TIMEOUT−1: `rsp_data`=0, `rsp_err`=1, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
  - The non-matching done input is ignored.
- RESP: `rsp_valid`=1. `rsp_data`, `rsp_op` and `rsp_err` are held stable until `rsp_ready`=1, then go to IDLE.
- `op_sel`, `opnd_a` and `opnd_b` hold their values from acceptance until the next acceptance.
- Done inputs are ignored in IDLE, EXEC and RESP. A done asserted during the start cycle is not honoured.
- `req_ready`=0 outside IDLE. A new request can be accepted no earlier than the cycle after the response handshake.

## Timing
- Reset (async assert, synchronous-style deassert by the system):
  - State: IDLE.
  - `req_ready`: 1.
  - `rsp_valid`, `rsp_err`, `mul_start`, `div_start`: 0.
  - `op_sel`, `rsp_op`: 000.
  - `opnd_a`, `opnd_b`, `rsp_data`, wait counter: 0.
- Reset mid-operation aborts the operation immediately. A done pulse that arrives after reset is ignored.
- Logic/add/sub latency: request accepted at edge N, EXEC during cycle N+1, `rsp_valid`=1 from cycle N+2.
- MULTI/DIV latency: start pulse in cycle N+1. If done is high in cycle M, `rsp_valid`=1 from cycle M+1.
- Timeout: `rsp_valid`=1 from cycle N+2+TIMEOUT.
- Back-to-back throughput for single-cycle ops, with `rsp_ready` held at 1: one operation per 3 cycles.

## Structure
- Shared `alu_pkg`:
  - Opcode localparams (NOT…DIV), reused by the result multiplexer.
  - State enum {IDLE, EXEC, WAIT, RESP}.
- Sub-module `alu_wait_timer`: clear/enable counter with a `expired` output at TIMEOUT−1, parameterised by TIMEOUT.

## Test plan
- ADD, a=8'h1E, b=8'h05, model `alu_res`=8'h23 → `rsp_valid` at N+2, `rsp_data`=8'h23, `rsp_op`=100, `rsp_err`=0, no start pulses.
- MULTI, a=8'h03, b=8'h04, `mul_done` driven 5 cycles after `mul_start` with `alu_res`=8'h0C → exactly one `mul_start` cycle, `rsp_data`=8'h0C one cycle after done.
- DIV, a=8'h10, b=8'h00 → no `div_start`, `rsp_data`=8'hFF, `rsp_err`=1 at N+2.
- DIV, b=8'h02, `div_done` never asserted, TIMEOUT=32 → `rsp_valid` at N+34, `rsp_data`=0, `rsp_err`=1; a later `div_done` pulse in IDLE is ignored.
- Response backpressure: `rsp_ready`=0 for 10 cycles → `rsp_*` stable, `req_ready`=0; a second `req_valid` is not accepted until the cycle after the handshake.
- `rst_n` low during WAIT of MULTI → all outputs at reset values immediately; the next XOR request completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings (also used by the result mux) and
// the dispatcher state type.
package alu_pkg;
  localparam logic [2:0] OP_NOT   = 3'b000;
  localparam logic [2:0] OP_AND   = 3'b001;
  localparam logic [2:0] OP_OR    = 3'b010;
  localparam logic [2:0] OP_XOR   = 3'b011;
  localparam logic [2:0] OP_ADD   = 3'b100;
  localparam logic [2:0] OP_SUB   = 3'b101;
  localparam logic [2:0] OP_MULTI = 3'b110;
  localparam logic [2:0] OP_DIV   = 3'b111;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_WAIT, ST_RESP} state_t;

  // MULTI and DIV are the only opcodes served by multi-cycle units
  function automatic logic is_multicycle(input logic [2:0] op);
    return op[2] & op[1];
  endfunction
endpackage

// File: rtl/alu_wait_timer.sv
// Clear/enable cycle counter; o_expired flags the count reaching TIMEOUT-1.
module alu_wait_timer #(
  parameter int TIMEOUT = 32
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + CW'(1);
  end

  assign o_expired = (r_cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/alu_op_dispatcher.sv
// ALU front-end sequencer: accepts one request, drives opcode/operands, runs
// the mul/div start/done handshake and returns the captured result.
module alu_op_dispatcher
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [2:0]       i_req_op,
  input  logic [WIDTH-1:0] i_req_a,
  input  logic [WIDTH-1:0] i_req_b,
  output logic [2:0]       o_op_sel,
  output logic [WIDTH-1:0] o_opnd_a,
  output logic [WIDTH-1:0] o_opnd_b,
  output logic             o_mul_start,
  output logic             o_div_start,
  input  logic             i_mul_done,
  input  logic             i_div_done,
  input  logic [WIDTH-1:0] i_alu_res,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_data,
  output logic [2:0]       o_rsp_op,
  output logic             o_rsp_err
);
  state_t           r_state;
  logic [2:0]       r_op_sel;
  logic [WIDTH-1:0] r_opnd_a, r_opnd_b, r_rsp_data;
  logic [2:0]       r_rsp_op;
  logic             r_rsp_err;
  logic             w_expired, w_done, w_div_zero;

  assign w_div_zero = (r_opnd_b == '0);
  // only the done line of the unit actually started is honoured
  assign w_done     = (r_op_sel == OP_MULTI) ? i_mul_done : i_div_done;

  alu_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (r_state == ST_EXEC),
    .i_en      (r_state == ST_WAIT),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_op_sel   <= '0;
      r_opnd_a   <= '0;
      r_opnd_b   <= '0;
      r_rsp_data <= '0;
      r_rsp_op   <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (i_req_valid) begin
          r_op_sel <= i_req_op;
          r_opnd_a <= i_req_a;
          r_opnd_b <= i_req_b;
          r_state  <= ST_EXEC;
        end
        ST_EXEC: begin
          r_rsp_op <= r_op_sel;
          if (!is_multicycle(r_op_sel)) begin
            r_rsp_data <= i_alu_res;
            r_rsp_err  <= 1'b0;
            r_state    <= ST_RESP;
          end else if (r_op_sel == OP_DIV && w_div_zero) begin
            r_rsp_data <= '1;
            r_rsp_err  <= 1'b1;
            r_state    <= ST_RESP;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: if (w_done) begin
          r_rsp_data <= i_alu_res;
          r_rsp_err  <= 1'b0;
          r_state    <= ST_RESP;
        end else if (w_expired) begin
          r_rsp_data <= '0;
          r_rsp_err  <= 1'b1;
          r_state    <= ST_RESP;
        end
        ST_RESP: if (i_rsp_ready) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_req_ready = (r_state == ST_IDLE);
  assign o_rsp_valid = (r_state == ST_RESP);
  assign o_mul_start = (r_state == ST_EXEC) && (r_op_sel == OP_MULTI);
  assign o_div_start = (r_state == ST_EXEC) && (r_op_sel == OP_DIV) && !w_div_zero;
  assign o_op_sel    = r_op_sel;
  assign o_opnd_a    = r_opnd_a;
  assign o_opnd_b    = r_opnd_b;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_op    = r_rsp_op;
  assign o_rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_alu_op_dispatcher.sv
// Randomized bench for alu_op_dispatcher; the bench plays the ALU result mux
// and the mul/div units, and predicts each response from the request alone.
module tb_alu_op_dispatcher;
  import alu_pkg::*;

  localparam int W  = 8;
  localparam int TO = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0, req_ready;
  logic [2:0]   req_op = '0;
  logic [W-1:0] req_a = '0, req_b = '0;
  logic [2:0]   op_sel, rsp_op;
  logic [W-1:0] opnd_a, opnd_b, alu_res, rsp_data;
  logic         mul_start, div_start, rsp_valid, rsp_err;
  logic         mul_done = 1'b0, div_done = 1'b0, rsp_ready = 1'b0;
  logic         unit_valid = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_op_dispatcher #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_op(req_op), .i_req_a(req_a), .i_req_b(req_b),
    .o_op_sel(op_sel), .o_opnd_a(opnd_a), .o_opnd_b(opnd_b),
    .o_mul_start(mul_start), .o_div_start(div_start),
    .i_mul_done(mul_done), .i_div_done(div_done),
    .i_alu_res(alu_res),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_data(rsp_data), .o_rsp_op(rsp_op), .o_rsp_err(rsp_err)
  );

  // Behavioural ALU: result of the expression selected by op_sel, over
  // whatever operands the dispatcher currently drives.
  function automatic logic [W-1:0] calc(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    case (op)
      3'd0:    return ~a;
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return a ^ b;
      3'd4:    return W'((ia + ib) % 256);
      3'd5:    return W'((ia - ib + 256) % 256);
      3'd6:    return W'((ia * ib) % 256);
      default: return (ib == 0) ? 8'h5A : W'(ia / ib);
    endcase
  endfunction

  // multi-cycle results are only visible once the unit has signalled done
  always_comb begin
    alu_res = calc(op_sel, opnd_a, opnd_b);
    if (op_sel[2] && op_sel[1] && !unit_valid) alu_res = 8'h5A;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // lat: cycles from the start cycle to the done pulse; negative = never
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int lat, input int bp);
    int k, guard, exp_lat, n_mul, n_div, exp_mul, exp_div, late_start;
    logic [W-1:0] exp_d;
    logic exp_e, match;
    exp_mul = (op == 3'd6) ? 1 : 0;
    exp_div = (op == 3'd7 && b != 0) ? 1 : 0;
    if (op < 3'd6) begin
      exp_d = calc(op, a, b); exp_e = 1'b0; exp_lat = 2;
    end else if (op == 3'd7 && b == 0) begin
      exp_d = 8'hFF; exp_e = 1'b1; exp_lat = 2;
    end else if (lat >= 1 && lat <= TO) begin
      exp_d = calc(op, a, b); exp_e = 1'b0; exp_lat = 2 + lat;
    end else begin
      exp_d = '0; exp_e = 1'b1; exp_lat = 2 + TO;
    end

    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; rsp_ready = 1'b0;
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    chk("accept_timeout", 32'(guard < 50), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; unit_valid = 1'b0;
    k = 1; n_mul = 0; n_div = 0; late_start = 0;
    while (k <= TO + 6) begin
      n_mul += int'(mul_start);
      n_div += int'(div_start);
      if ((mul_start || div_start) && k != 1) late_start++;
      if (rsp_valid) break;
      match = (lat >= 0) && (k == 1 + lat);
      mul_done = (op == 3'd6) ? match : 1'($urandom_range(0, 1));
      div_done = (op == 3'd7) ? match : 1'($urandom_range(0, 1));
      if (match && op[2] && op[1]) unit_valid = 1'b1;
      @(negedge clk);
      k++;
    end
    mul_done = 1'b0; div_done = 1'b0;
    chk("rsp_latency", 32'(k), 32'(exp_lat));
    chk("rsp_data", 32'(rsp_data), 32'(exp_d));
    chk("rsp_op", 32'(rsp_op), 32'(op));
    chk("rsp_err", 32'(rsp_err), 32'(exp_e));
    chk("mul_starts", 32'(n_mul), 32'(exp_mul));
    chk("div_starts", 32'(n_div), 32'(exp_div));
    chk("start_not_exec", 32'(late_start), 32'd0);

    // hold off the response while a second request waits
    for (int i = 0; i < bp; i++) begin
      req_valid = 1'b1; req_op = ~op; req_a = ~a;
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", 32'(rsp_data), 32'(exp_d));
      chk("bp_err", 32'(rsp_err), 32'(exp_e));
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_op_sel", 32'(op_sel), 32'(op));
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_hs_valid", 32'(rsp_valid), 32'd0);
    chk("post_hs_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_starts"}, 32'({mul_start, div_start}), 32'd0);
    chk({tag, "_op_sel"}, 32'(op_sel), 32'd0);
    chk({tag, "_rsp_op"}, 32'(rsp_op), 32'd0);
    chk({tag, "_opnds"}, 32'({opnd_a, opnd_b}), 32'd0);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
  endtask

  initial begin
    int lat, sel, guard;
    logic [W-1:0] ra, rb;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    run_op(OP_ADD, 8'h1E, 8'h05, 0, 0);
    run_op(OP_MULTI, 8'h03, 8'h04, 5, 0);
    run_op(OP_DIV, 8'h10, 8'h00, 3, 0);
    run_op(OP_DIV, 8'h10, 8'h02, -1, 0);
    // stray done pulses while idle
    div_done = 1'b1; mul_done = 1'b1;
    @(negedge clk);
    div_done = 1'b0; mul_done = 1'b0;
    @(negedge clk);
    chk("idle_done_valid", 32'(rsp_valid), 32'd0);
    chk("idle_done_ready", 32'(req_ready), 32'd1);
    run_op(OP_AND, 8'hF0, 8'h3C, 0, 10);
    run_op(OP_MULTI, 8'h07, 8'h09, TO, 0);
    run_op(OP_MULTI, 8'h07, 8'h09, TO + 1, 0);
    run_op(OP_DIV, 8'hC8, 8'h07, 0, 0);

    // reset in the middle of a MULTI wait
    req_valid = 1'b1; req_op = OP_MULTI; req_a = 8'h22; req_b = 8'h33;
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midop_reset");
    @(negedge clk);
    rst_n = 1'b1;
    mul_done = 1'b1;
    @(negedge clk);
    mul_done = 1'b0;
    @(negedge clk);
    chk("post_reset_done_valid", 32'(rsp_valid), 32'd0);
    chk("post_reset_done_ready", 32'(req_ready), 32'd1);
    run_op(OP_XOR, 8'hA5, 8'h0F, 0, 1);

    for (int n = 0; n < 40; n++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      sel = int'($urandom_range(0, 5));
      case (sel)
        0:       lat = -1;
        1:       lat = 0;
        2:       lat = 1;
        3:       lat = TO;
        4:       lat = TO + 1;
        default: lat = int'($urandom_range(1, TO));
      endcase
      run_op(3'($urandom_range(0, 7)), ra, rb, lat, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
